// File: rtl/alu_share_arb_pkg.sv
// Shared execute-stage constants: operand width, opcode width and ALU opcodes.
// Stands in for the CPU_Parameter.vh header values used by alu_share_arb.
package alu_share_arb_pkg;

    localparam int WORD       = 32;
    localparam int OPCODE_LEN = 4;
    localparam int TAG_LEN    = 5;

    typedef enum logic [OPCODE_LEN-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_e;

    // Anything above SLTU is undefined and reported as an error.
    function automatic logic op_illegal(input logic [OPCODE_LEN-1:0] op);
        return op > ALU_SLTU;
    endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational integer ALU; undefined opcodes produce zero.
module alu_share_arb_alu
    import alu_share_arb_pkg::*;
#(
    parameter int W    = WORD,
    parameter int OP_W = OPCODE_LEN
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    in0,
    input  logic [W-1:0]    in1,
    output logic [W-1:0]    out
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] shamt;
    assign shamt = in1[SH_W-1:0];

    always_comb begin
        out = '0;
        case (op)
            ALU_ADD:  out = in0 + in1;
            ALU_SUB:  out = in0 - in1;
            ALU_AND:  out = in0 & in1;
            ALU_OR:   out = in0 | in1;
            ALU_XOR:  out = in0 ^ in1;
            ALU_SLL:  out = in0 << shamt;
            ALU_SRL:  out = in0 >> shamt;
            ALU_SLTU: out = {{(W-1){1'b0}}, (in0 < in1)};
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing the execute-stage ALU, with a one-entry response register.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int W     = WORD,
    parameter int OP_W  = OPCODE_LEN,
    parameter int TAG_W = TAG_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    logic            can_issue, grant0, grant1, accept, sel1;
    logic [OP_W-1:0] alu_op;
    logic [W-1:0]    alu_a, alu_b, alu_out;

    assign can_issue = ~rsp_valid | rsp_ready;

`ifdef ALU_ARB_RR_EN
    // ptr names the port favoured under contention; flips on every accept.
    logic ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (accept)
            ptr <= ~ptr;
    end
    assign grant0 = req0_valid & (~req1_valid | ~ptr);
    assign grant1 = req1_valid & (~req0_valid | ptr);
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = grant0 & can_issue & ~rst;
    assign req1_ready = grant1 & can_issue & ~rst;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel1       = req1_valid & req1_ready;

    assign alu_op = sel1 ? req1_op : req0_op;
    assign alu_a  = sel1 ? req1_a  : req0_a;
    assign alu_b  = sel1 ? req1_b  : req0_b;

    alu_share_arb_alu #(.W(W), .OP_W(OP_W)) u_alu (
        .op  (alu_op),
        .in0 (alu_a),
        .in1 (alu_b),
        .out (alu_out)
    );

    // Payload registers only load on accept, so they hold after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_out;
            rsp_id    <= sel1;
            rsp_tag   <= sel1 ? req1_tag : req0_tag;
            rsp_err   <= op_illegal(alu_op);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbiter and sequencer that shares the single execute-stage integer ALU between two requesters: port 0 for the main issue path and port 1 for the address/branch-compare path. It grants at most one request per cycle, drives the combinational ALU with the granted operands and registers the result in a one-entry response stage with a valid/ready handshake. It sits between the issue logic and writeback, and is the only instantiator of the ALU in the execute stage.

## Interface
- WORD, 32, operand/result width (from the shared header)
- OP_W, 4, ALU opcode width (matches `OPCODE_LEN`)
- TAG_W, 5, opaque requester tag width (destination register index)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OP_W  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  WORD  operands (in0, in1)
- req0_tag / req1_tag  in  TAG_W  tag, returned unchanged
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  WORD  ALU result
- rsp_id  out  1  source port of the response (0 or 1)
- rsp_tag  out  TAG_W  tag of the response
- rsp_err  out  1  opcode was not one of ADD/SUB/AND/OR/XOR/SLL/SRL/SLTU

## Operation
- can_issue = !rsp_valid | rsp_ready. When can_issue is 0, both readies are 0.
- Grant: with one valid request, that port is granted. With both valid, the arbitration policy applies (see Configuration).
- reqN_ready = grantN & can_issue & !rst. The grant is combinational from the valids and the pointer, and does not depend on the ready outputs.
- Accept (reqN_valid & reqN_ready): the granted op, a and b drive the ALU. On the next edge, rsp_data, rsp_id, rsp_tag and rsp_err load and rsp_valid is set to 1.
- rsp_err = 1 when the opcode is outside the eight defined codes. rsp_data is then 0, which is the ALU default.
- Drain without a new accept (rsp_valid & rsp_ready): rsp_valid clears to 0. The data, id, tag and err registers hold their values.
- Simultaneous drain and accept: the response register is overwritten with the new result and rsp_valid stays at 1.
- The response registers hold stable while rsp_valid & !rsp_ready.
- Requesters must hold their valid and payload until ready. The block does not sample a request that is withdrawn before it is accepted.

## Timing
- Reset values: rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_tag = 0, rsp_err = 0, priority pointer = 0 (port 0 favoured). req0_ready and req1_ready are 0 while rst is high.
- Latency: accept in cycle N, rsp_valid = 1 in cycle N+1.
- Throughput: 1 response per cycle while rsp_ready is held high.
- Reset asserted mid-operation: any pending response is discarded immediately (asynchronous clear), and an accept in the same cycle is lost.
- The ALU input-to-output path is combinational. The only registered path is the ALU output into rsp_data.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration. A 1-bit pointer names the favoured port.
  - On each accept, the pointer moves to the other port.
  - With both ports valid, the favoured port is granted.
  - With one port valid, that port is granted and the pointer still advances after the accept.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins. The pointer register is not built and the reset value for the pointer does not apply.

## Structure
- The shared header `CPU_Parameter.vh` holds `WORD`, `OPCODE_LEN` and the `ALU_*` opcode constants. This block adds no new opcodes.
- The ALU is the natural sub-module: instantiate it once, unmodified.
- Arbitration (grant and pointer) and the response register stay in this module.

## Test plan
- Single request, port 0: op ADD, a = 0x0000_0005, b = 0x0000_0003, tag = 7, rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_data = 0x8, rsp_id = 0, rsp_tag = 7, rsp_err = 0.
- Contention, `ALU_ARB_RR_EN` defined: both ports valid for 4 cycles with rsp_ready = 1 -> grants alternate 0,1,0,1. With the macro undefined, port 0 is granted all 4 cycles and req1_ready stays 0.
- Backpressure: rsp_ready = 0 with a response held (SUB, 0x10 - 0x1 = 0xF) -> both readies are 0 and rsp_data stays 0xF. Raising rsp_ready with port 1 valid (SLL 0x1 by 4) -> next cycle rsp_data = 0x10, rsp_id = 1, and rsp_valid never drops.
- Illegal opcode on port 1 -> rsp_err = 1, rsp_data = 0, tag returned unchanged.
- Shift and compare edges: SRL 0x8000_0000 by 0x3F (only the low 5 bits are used) -> 0x1. SLTU 0x0 < 0xFFFF_FFFF -> 0x1.
- Reset mid-stream: assert rst while rsp_valid = 1 -> rsp_valid = 0 immediately and both readies are 0. After release, the first contended grant goes to port 0.
